mem_arbiter_rr: RTL

- Parametrised successor to the dual-core RAM arbiter.
- Arbitrates a single RAM port between NCPU instruction-fetch channels and one data/coherence channel. The data/coherence channel is the single request stream already serialised by the coherence controller.
- Instruction channels use a registered round-robin grant with a starvation limit on data priority.
- Sits between the caches/coherence unit and the RAM model in the multicore memory subsystem.

---
 rtl/mem_arbiter_rr.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr
// Round-robin arbiter that shares one RAM port between NCPU instruction-fetch
// channels and a single data/coherence channel. Instruction channels rotate
// through a registered round-robin pointer. The data channel wins ties, but
// only until it has taken STARVE_LIMIT consecutive grants while a fetch waits.
//
// Ports
//   CLK, RST        clock, synchronous active-high reset
//   ireq/iaddr      per-CPU fetch request and address (CPU i at [i*AW +: AW])
//   iwait/iload     per-CPU wait, broadcast fetch data
//   dren/dwen       data read/write request; daddr/dstore address and data
//   dwait/dload     data wait, read data
//   ramREN/ramWEN   RAM enables; ramaddr/ramstore address and write data
//   ramload         RAM read data
//   ramstate        RAM status, encoded FREE=0 BUSY=1 ACCESS=2 ERROR=3
//   arb_timeout     one-cycle pulse when a stalled grant is abandoned
//
// Build option
//   MEM_ARB_WATCHDOG_EN  enables the WDOG_CYCLES grant watchdog. When it is
//                        not defined, arb_timeout stays 0 and a grant is held
//                        for as long as the RAM stalls.
//
// State table
//   state | meaning
//   IDLE  | no grant, RAM enables low, next owner chosen here
//   GNT_I | fetch granted to owner_q, waiting for ACCESS
//   GNT_D | data channel granted, waiting for ACCESS
module mem_arbiter_rr #(
    parameter int NCPU         = 2,
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int WDOG_CYCLES  = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NCPU-1:0]   ireq,
    input  logic [NCPU*AW-1:0] iaddr,
    output logic [NCPU-1:0]   iwait,
    output logic [DW-1:0]     iload,
    input  logic              dren,
    input  logic              dwen,
    input  logic [AW-1:0]     daddr,
    input  logic [DW-1:0]     dstore,
    output logic              dwait,
    output logic [DW-1:0]     dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [AW-1:0]     ramaddr,
    output logic [DW-1:0]     ramstore,
    input  logic [DW-1:0]     ramload,
    input  logic [1:0]        ramstate,
    output logic              arb_timeout
);

    localparam int PW = (NCPU > 1) ? $clog2(NCPU) : 1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [3:0] DLIM = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [3:0]      dcount_q, dcount_d;

    logic [AW-1:0]   iaddr_a [NCPU];
    logic            access;
    logic            wd_expire;
    logic            pick_valid;
    logic [PW-1:0]   pick_idx;
    logic [PW-1:0]   cand;

    assign iload  = ramload;
    assign dload  = ramload;
    assign access = (ramstate == RS_ACCESS);

    for (genvar g = 0; g < NCPU; g++) begin : g_iaddr
        assign iaddr_a[g] = iaddr[g*AW +: AW];
    end

    // First pending CPU strictly after the last completed owner, wrapping.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NCPU; k++) begin
            cand = PW'((int'(rr_ptr_q) + k) % NCPU);
            if (!pick_valid && ireq[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

`ifdef MEM_ARB_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    logic [WW-1:0] wdog_q, wdog_d;

    // Every grant is entered from IDLE, so holding the counter at zero there
    // is the same as clearing it on grant entry.
    always_comb begin
        wdog_d = wdog_q;
        if (state_q == IDLE) begin
            wdog_d = '0;
        end else if (!access) begin
            wdog_d = wdog_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end

    assign wd_expire = (state_q != IDLE) && !access &&
                       (wdog_q == WW'(WDOG_CYCLES - 1));
`else
    assign wd_expire = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        dcount_d    = dcount_q;
        iwait       = '1;
        dwait       = 1'b1;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        arb_timeout = 1'b0;

        case (state_q)
            IDLE: begin
                if ((dren || dwen) && !(dcount_q == DLIM && |ireq)) begin
                    state_d = GNT_D;
                    // Count only data grants that actually made a fetch wait.
                    if (|ireq) begin
                        dcount_d = (dcount_q == DLIM) ? dcount_q : dcount_q + 4'd1;
                    end else begin
                        dcount_d = '0;
                    end
                end else if (pick_valid) begin
                    state_d = GNT_I;
                    owner_d = pick_idx;
                end
            end

            GNT_I: begin
                ramREN  = 1'b1;
                ramaddr = iaddr_a[owner_q];
                if (access) begin
                    iwait[owner_q] = 1'b0;
                    rr_ptr_d       = owner_q;
                    dcount_d       = '0;
                    state_d        = IDLE;
                end else if (!ireq[owner_q]) begin
                    state_d = IDLE;
                end else if (wd_expire) begin
                    // Abandon the owner but still rotate past it.
                    arb_timeout = 1'b1;
                    rr_ptr_d    = owner_q;
                    state_d     = IDLE;
                end
            end

            GNT_D: begin
                if (dwen) begin
                    ramWEN = 1'b1;
                end else begin
                    ramREN = 1'b1;
                end
                ramaddr  = daddr;
                ramstore = dstore;
                if (access) begin
                    dwait   = 1'b0;
                    state_d = IDLE;
                end else if (!dren && !dwen) begin
                    state_d = IDLE;
                end else if (wd_expire) begin
                    // A stalled data owner hands the next slot to fetches.
                    arb_timeout = 1'b1;
                    dcount_d    = DLIM;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset drops the grant in the same cycle it is asserted.
        if (RST) begin
            iwait       = '1;
            dwait       = 1'b1;
            ramREN      = 1'b0;
            ramWEN      = 1'b0;
            ramaddr     = '0;
            ramstore    = '0;
            arb_timeout = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= PW'(NCPU - 1);
            dcount_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            dcount_q <= dcount_d;
        end
    end

endmodule
